// File: rtl/vend_controller.sv
// Vending transaction sequencer: collects coin credit, latches the selected price,
// requests a buy from the datapath, then dispenses, pays change or refunds.
module vend_controller #(
  parameter int unsigned COIN_V0     = 1,
  parameter int unsigned COIN_V1     = 5,
  parameter int unsigned COIN_V2     = 10,
  parameter int unsigned COIN_V3     = 20,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned DISP_CYC    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coin_valid,
  input  logic [1:0]  coin_sel,
  input  logic        sel_valid,
  input  logic [7:0]  sel_price,
  input  logic        cancel,
  input  logic [1:0]  txn_state,
  input  logic [11:0] txn_change,
  output logic [11:0] currency,
  output logic [7:0]  goods_price,
  output logic        buy_goods,
  output logic        dispense,
  output logic [11:0] change_out,
  output logic        change_valid,
  output logic        short_flag,
  output logic        coin_reject,
  output logic        busy,
  output logic [2:0]  fsm_state
);

  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC);
  localparam int unsigned DISP_W = $clog2(DISP_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLECT  = 3'd1,
    S_EVAL     = 3'd2,
    S_DISPENSE = 3'd3,
    S_PAYOUT   = 3'd4,
    S_REFUND   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [11:0]         currency_q, currency_d;
  logic [7:0]          goods_price_q, goods_price_d;
  logic [11:0]         change_out_q, change_out_d;
  logic                coin_reject_q, coin_reject_d;
  logic                short_flag_q, short_flag_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [DISP_W-1:0]   disp_q, disp_d;

  logic [11:0]         coin_val;
  logic [12:0]         coin_sum;
  logic                coin_fits;

  always_comb begin
    case (coin_sel)
      2'd0:    coin_val = 12'(COIN_V0);
      2'd1:    coin_val = 12'(COIN_V1);
      2'd2:    coin_val = 12'(COIN_V2);
      default: coin_val = 12'(COIN_V3);
    endcase
    coin_sum  = {1'b0, currency_q} + {1'b0, coin_val};
    coin_fits = ~coin_sum[12];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      currency_q    <= '0;
      goods_price_q <= '0;
      change_out_q  <= '0;
      coin_reject_q <= 1'b0;
      short_flag_q  <= 1'b0;
      tmo_q         <= '0;
      disp_q        <= '0;
    end else begin
      state_q       <= state_d;
      currency_q    <= currency_d;
      goods_price_q <= goods_price_d;
      change_out_q  <= change_out_d;
      coin_reject_q <= coin_reject_d;
      short_flag_q  <= short_flag_d;
      tmo_q         <= tmo_d;
      disp_q        <= disp_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    currency_d    = currency_q;
    goods_price_d = goods_price_q;
    change_out_d  = change_out_q;
    coin_reject_d = 1'b0;
    short_flag_d  = 1'b0;
    tmo_d         = tmo_q;
    disp_d        = disp_q;
    case (state_q)
      S_IDLE: begin
        if (coin_valid) begin
          currency_d = coin_sum[11:0];
          tmo_d      = '0;
          state_d    = S_COLLECT;
        end
      end
      S_COLLECT: begin
        tmo_d = tmo_q + 1'b1;
        if (cancel) begin
          change_out_d = currency_q;
          currency_d   = '0;
          state_d      = S_REFUND;
        end else if (sel_valid) begin
          goods_price_d = sel_price;
          tmo_d         = '0;
          state_d       = S_EVAL;
        end else if (coin_valid && coin_fits) begin
          currency_d = coin_sum[11:0];
          tmo_d      = '0;
        end else begin
          // A refused coin is not activity, so expiry may coincide with it
          coin_reject_d = coin_valid;
          if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            change_out_d = currency_q;
            currency_d   = '0;
            state_d      = S_REFUND;
          end
        end
      end
      S_EVAL: begin
        coin_reject_d = coin_valid;
        case (txn_state)
          2'b00: begin
            change_out_d = txn_change;
            currency_d   = '0;
            disp_d       = '0;
            state_d      = S_DISPENSE;
          end
          2'b01: begin
            change_out_d = '0;
            currency_d   = '0;
            disp_d       = '0;
            state_d      = S_DISPENSE;
          end
          2'b10: begin
            short_flag_d = 1'b1;
            tmo_d        = '0;
            state_d      = S_COLLECT;
          end
          default: begin
            change_out_d = currency_q;
            currency_d   = '0;
            state_d      = S_REFUND;
          end
        endcase
      end
      S_DISPENSE: begin
        coin_reject_d = coin_valid;
        disp_d        = disp_q + 1'b1;
        if (disp_q == DISP_W'(DISP_CYC - 1)) state_d = S_PAYOUT;
      end
      S_PAYOUT: begin
        coin_reject_d = coin_valid;
        state_d       = S_IDLE;
      end
      S_REFUND: begin
        coin_reject_d = coin_valid;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    buy_goods    = (state_q == S_EVAL);
    dispense     = (state_q == S_DISPENSE);
    change_valid = (state_q == S_PAYOUT) || (state_q == S_REFUND);
    busy         = (state_q == S_EVAL) || (state_q == S_DISPENSE) || (state_q == S_PAYOUT);
  end

  assign currency    = currency_q;
  assign goods_price = goods_price_q;
  assign change_out  = change_out_q;
  assign coin_reject = coin_reject_q;
  assign short_flag  = short_flag_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed and randomized transactions checked against
// a transaction-level credit/price model.
module tb_vend_controller;
  localparam int TMO  = 40;
  localparam int DISP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        coin_valid;
  logic [1:0]  coin_sel;
  logic        sel_valid;
  logic [7:0]  sel_price;
  logic        cancel;
  logic [1:0]  txn_state;
  logic [11:0] txn_change;
  logic [11:0] currency;
  logic [7:0]  goods_price;
  logic        buy_goods;
  logic        dispense;
  logic [11:0] change_out;
  logic        change_valid;
  logic        short_flag;
  logic        coin_reject;
  logic        busy;
  logic [2:0]  fsm_state;

  int checks = 0;
  int fails  = 0;
  int credit = 0;

  vend_controller #(
    .COIN_V0(1), .COIN_V1(5), .COIN_V2(10), .COIN_V3(20),
    .TIMEOUT_CYC(TMO), .DISP_CYC(DISP)
  ) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .sel_valid(sel_valid), .sel_price(sel_price), .cancel(cancel),
    .txn_state(txn_state), .txn_change(txn_change), .currency(currency),
    .goods_price(goods_price), .buy_goods(buy_goods), .dispense(dispense),
    .change_out(change_out), .change_valid(change_valid), .short_flag(short_flag),
    .coin_reject(coin_reject), .busy(busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  function automatic int coin_value(input int sel);
    int vals[4] = '{1, 5, 10, 20};
    return vals[sel];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic insert_coin(input int sel);
    int v;
    v = coin_value(sel);
    coin_valid = 1'b1;
    coin_sel   = 2'(sel);
    tick();
    coin_valid = 1'b0;
    if (credit + v > 4095) begin
      chk("coin_reject_ovf", coin_reject, 1);
    end else begin
      credit += v;
      chk("coin_reject_ok", coin_reject, 0);
    end
    chk("coin_credit", currency, credit);
    chk("coin_state", fsm_state, 1);
  endtask

  task automatic do_cancel(input bit extra_coin, input bit extra_sel);
    cancel     = 1'b1;
    coin_valid = extra_coin;
    coin_sel   = 2'd3;
    sel_valid  = extra_sel;
    sel_price  = 8'd1;
    tick();
    cancel = 1'b0; coin_valid = 1'b0; sel_valid = 1'b0;
    chk("cancel_state", fsm_state, 5);
    chk("cancel_cv", change_valid, 1);
    chk("cancel_change", change_out, credit);
    chk("cancel_credit", currency, 0);
    chk("cancel_reject", coin_reject, 0);
    tick();
    chk("cancel_idle", fsm_state, 0);
    chk("cancel_cv_off", change_valid, 0);
    credit = 0;
  endtask

  // Verdict chosen as an ideal datapath would: compare credit with price.
  task automatic purchase(input int price, input bit coin_in_eval,
                          input bit coin_with_sel, input bit fault);
    int vs;
    int chg;
    chg = 0;
    if (fault)               vs = 3;
    else if (credit > price) vs = 0;
    else if (credit == price) vs = 1;
    else                     vs = 2;
    txn_state  = 2'(vs);
    txn_change = (vs == 0) ? 12'(credit - price) : 12'($urandom);
    if (vs == 0) chg = credit - price;
    sel_valid  = 1'b1;
    sel_price  = 8'(price);
    coin_valid = coin_with_sel;
    coin_sel   = 2'd1;
    tick();
    sel_valid = 1'b0; coin_valid = 1'b0;
    chk("eval_state", fsm_state, 2);
    chk("eval_buy", buy_goods, 1);
    chk("eval_busy", busy, 1);
    chk("eval_price", goods_price, price);
    chk("eval_credit", currency, credit);
    chk("eval_reject", coin_reject, 0);
    coin_valid = coin_in_eval;
    coin_sel   = 2'($urandom);
    tick();
    coin_valid = 1'b0;
    chk("eval_coin_reject", coin_reject, int'(coin_in_eval));
    chk("post_eval_buy", buy_goods, 0);
    if (vs <= 1) begin
      chk("disp_state", fsm_state, 3);
      chk("disp_credit", currency, 0);
      chk("disp_change", change_out, chg);
      chk("disp_on", dispense, 1);
      for (int i = 1; i < DISP; i++) begin
        tick();
        chk("disp_hold", dispense, 1);
        chk("disp_nobuy", buy_goods, 0);
      end
      tick();
      chk("pay_state", fsm_state, 4);
      chk("pay_disp_off", dispense, 0);
      chk("pay_cv", change_valid, 1);
      chk("pay_change", change_out, chg);
      chk("pay_busy", busy, 1);
      tick();
      chk("pay_idle", fsm_state, 0);
      chk("pay_cv_off", change_valid, 0);
      chk("idle_busy", busy, 0);
      credit = 0;
    end else if (vs == 2) begin
      chk("short_state", fsm_state, 1);
      chk("short_flag", short_flag, 1);
      chk("short_credit", currency, credit);
      tick();
      chk("short_flag_off", short_flag, 0);
    end else begin
      chk("fault_state", fsm_state, 5);
      chk("fault_cv", change_valid, 1);
      chk("fault_change", change_out, credit);
      chk("fault_credit", currency, 0);
      tick();
      chk("fault_idle", fsm_state, 0);
      credit = 0;
    end
  endtask

  initial begin
    rst = 1'b0; coin_valid = 1'b0; coin_sel = '0; sel_valid = 1'b0;
    sel_price = '0; cancel = 1'b0; txn_state = 2'b11; txn_change = '0;
    tick(); tick();
    rst = 1'b1;
    chk("rst_state", fsm_state, 0);
    chk("rst_credit", currency, 0);
    chk("rst_price", goods_price, 0);
    chk("rst_change", change_out, 0);
    chk("rst_pulses", {buy_goods, dispense, change_valid, short_flag, coin_reject, busy}, 0);

    sel_valid = 1'b1; cancel = 1'b1;
    tick();
    sel_valid = 1'b0; cancel = 1'b0;
    chk("idle_ignore", fsm_state, 0);

    insert_coin(3); insert_coin(3); insert_coin(2);
    purchase(35, 1'b0, 1'b0, 1'b0);

    insert_coin(3);
    purchase(20, 1'b1, 1'b0, 1'b0);

    insert_coin(1);
    purchase(30, 1'b0, 1'b0, 1'b0);
    insert_coin(3); insert_coin(1);
    purchase(30, 1'b0, 1'b0, 1'b0);

    insert_coin(2); insert_coin(1);
    do_cancel(1'b1, 1'b1);

    insert_coin(2);
    for (int i = 1; i < TMO; i++) tick();
    chk("tmo_before", fsm_state, 1);
    tick();
    chk("tmo_state", fsm_state, 5);
    chk("tmo_change", change_out, 10);
    chk("tmo_cv", change_valid, 1);
    tick();
    chk("tmo_idle", fsm_state, 0);
    credit = 0;

    for (int i = 0; i < 204; i++) insert_coin(3);
    insert_coin(2);
    chk("credit_4090", currency, 4090);
    insert_coin(2);
    insert_coin(1);
    chk("credit_4095", currency, 4095);
    insert_coin(0);
    do_cancel(1'b0, 1'b0);

    insert_coin(1);
    purchase(3, 1'b0, 1'b1, 1'b0);

    insert_coin(2);
    purchase(7, 1'b0, 1'b0, 1'b1);

    insert_coin(3);
    txn_state = 2'b00; txn_change = 12'd10;
    sel_valid = 1'b1; sel_price = 8'd10;
    tick();
    sel_valid = 1'b0;
    tick(); tick();
    chk("pre_rst_disp", dispense, 1);
    rst = 1'b0;
    tick();
    chk("mid_rst_state", fsm_state, 0);
    chk("mid_rst_outs", {buy_goods, dispense, change_valid, short_flag, coin_reject, busy}, 0);
    chk("mid_rst_credit", currency, 0);
    chk("mid_rst_change", change_out, 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_cv", change_valid, 0);
      chk("post_rst_state", fsm_state, 0);
    end
    credit = 0;

    for (int t = 0; t < 30; t++) begin
      int n;
      n = int'($urandom_range(1, 5));
      for (int c = 0; c < n; c++) insert_coin(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 5) == 0) begin
        do_cancel(1'($urandom), 1'($urandom));
      end else begin
        purchase(int'($urandom_range(0, 120)), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0));
        if (fsm_state == 3'd1) do_cancel(1'b0, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
